// File: rtl/pong_game_engine.sv
// Ball physics, paddle collision, scoring and game FSM for two-player pong.
// The ball advances one SPEED step per frame tick while in PLAY.
module pong_game_engine #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 10,
    parameter int PADDLE_W    = 10,
    parameter int PADDLE_H    = 50,
    parameter int P1_X        = 20,
    parameter int P2_X        = 620,
    parameter int SPEED       = 2,
    parameter int WIN_SCORE   = 10,
    parameter int SERVE_TICKS = 60
) (
    input  logic        board_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        tick,
    input  logic [9:0]  p1_pos,
    input  logic [9:0]  p2_pos,
    output logic [10:0] ball_x,
    output logic [9:0]  ball_y,
    output logic [3:0]  p1_score,
    output logic [3:0]  p2_score,
    output logic [1:0]  state,
    output logic        point_p1,
    output logic        point_p2
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SERVE = 2'b01;
    localparam logic [1:0] PLAY  = 2'b10;
    localparam logic [1:0] DONE  = 2'b11;

    localparam logic [10:0] CX   = 11'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]  CY   = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [9:0]  PMAX = 10'(SCREEN_H - PADDLE_H);
    localparam logic signed [11:0] SPD     = 12'(SPEED);
    localparam logic signed [11:0] XMAX    = 12'(SCREEN_W - BALL_SIZE);
    localparam logic signed [11:0] YMAX    = 12'(SCREEN_H - BALL_SIZE);
    localparam logic signed [11:0] P1_EDGE = 12'(P1_X + PADDLE_W);
    localparam logic signed [11:0] P2_EDGE = 12'(P2_X - BALL_SIZE);
    localparam logic signed [11:0] BSZ     = 12'(BALL_SIZE);
    localparam logic signed [11:0] PH      = 12'(PADDLE_H);
    localparam int CW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_TICKS - 1);
    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    logic          start_q, dx_left, dy_up;
    logic [CW-1:0] serve_cnt;
    logic [9:0]    p1c, p2c;
    logic signed [11:0] bx, by, nx, ny, p1s, p2s;
    logic          p1_hit, p2_hit, miss_l, miss_r, start_rise;
    logic [3:0]    p1_inc, p2_inc;

    always_comb begin
        p1c = (p1_pos > PMAX) ? PMAX : p1_pos;
        p2c = (p2_pos > PMAX) ? PMAX : p2_pos;
        p1s = {2'b00, p1c};
        p2s = {2'b00, p2c};
        bx  = {1'b0, ball_x};
        by  = {2'b00, ball_y};
        nx  = dx_left ? bx - SPD : bx + SPD;
        ny  = dy_up   ? by - SPD : by + SPD;
        // paddle contact needs the step to reach the paddle face and vertical overlap
        p1_hit = dx_left && (bx >= P1_EDGE) && (nx <= P1_EDGE)
                 && (by + BSZ > p1s) && (by < p1s + PH);
        p2_hit = !dx_left && (bx <= P2_EDGE) && (nx >= P2_EDGE)
                 && (by + BSZ > p2s) && (by < p2s + PH);
        miss_l = dx_left && (bx < SPD);
        miss_r = !dx_left && (nx > XMAX);
        p1_inc = (p1_score == 4'hF) ? p1_score : p1_score + 4'd1;
        p2_inc = (p2_score == 4'hF) ? p2_score : p2_score + 4'd1;
        start_rise = start && !start_q;
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            p1_score  <= '0;
            p2_score  <= '0;
            ball_x    <= CX;
            ball_y    <= CY;
            dx_left   <= 1'b0;
            dy_up     <= 1'b0;
            serve_cnt <= '0;
            start_q   <= 1'b0;
            point_p1  <= 1'b0;
            point_p2  <= 1'b0;
        end else begin
            start_q  <= start;
            point_p1 <= 1'b0;
            point_p2 <= 1'b0;
            case (state)
                IDLE, DONE: if (start_rise) begin
                    state     <= SERVE;
                    p1_score  <= '0;
                    p2_score  <= '0;
                    dx_left   <= 1'b0;
                    serve_cnt <= '0;
                    ball_x    <= CX;
                    ball_y    <= CY;
                end
                SERVE: if (tick) begin
                    if (serve_cnt == SERVE_LAST) begin
                        state     <= PLAY;
                        serve_cnt <= '0;
                    end else begin
                        serve_cnt <= serve_cnt + 1'b1;
                    end
                end
                PLAY: if (tick) begin
                    if (miss_l || miss_r) begin
                        // serve goes toward whoever conceded; dy is kept
                        ball_x  <= CX;
                        ball_y  <= CY;
                        dx_left <= miss_l;
                        if (miss_l) begin
                            p2_score <= p2_inc;
                            point_p2 <= 1'b1;
                            state    <= (p2_inc == WIN) ? DONE : SERVE;
                        end else begin
                            p1_score <= p1_inc;
                            point_p1 <= 1'b1;
                            state    <= (p1_inc == WIN) ? DONE : SERVE;
                        end
                    end else begin
                        if (p1_hit) begin
                            ball_x  <= P1_EDGE[10:0];
                            dx_left <= 1'b0;
                        end else if (p2_hit) begin
                            ball_x  <= P2_EDGE[10:0];
                            dx_left <= 1'b1;
                        end else begin
                            ball_x  <= nx[10:0];
                        end
                        if (ny[11]) begin
                            ball_y <= '0;
                            dy_up  <= 1'b0;
                        end else if (ny > YMAX) begin
                            ball_y <= YMAX[9:0];
                            dy_up  <= 1'b1;
                        end else begin
                            ball_y <= ny[9:0];
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pong_game_engine.sv
// Self-checking bench: scripted vector table, directed miss/reset sequences and a
// long randomized run against a plain-arithmetic reference model of the game rules.
module tb_pong_game_engine;
    logic        board_clk = 1'b0;
    logic        reset, start, tick;
    logic [9:0]  p1_pos, p2_pos;
    logic [10:0] ball_x;
    logic [9:0]  ball_y;
    logic [3:0]  p1_score, p2_score;
    logic [1:0]  state;
    logic        point_p1, point_p2;

    int checks = 0;
    int errors = 0;

    pong_game_engine dut (
        .board_clk(board_clk), .reset(reset), .start(start), .tick(tick),
        .p1_pos(p1_pos), .p2_pos(p2_pos), .ball_x(ball_x), .ball_y(ball_y),
        .p1_score(p1_score), .p2_score(p2_score), .state(state),
        .point_p1(point_p1), .point_p2(point_p2)
    );

    always #5 board_clk = ~board_clk;

    // reference model: game rules in integer arithmetic, velocities as signed steps
    int m_st, m_x, m_y, m_vx, m_vy, m_s1, m_s2, m_cnt, m_pp1, m_pp2;
    bit m_prev;

    task automatic model_reset();
        m_st = 0; m_x = 315; m_y = 235; m_vx = 2; m_vy = 2;
        m_s1 = 0; m_s2 = 0; m_cnt = 0; m_pp1 = 0; m_pp2 = 0; m_prev = 0;
    endtask

    task automatic model_point(input bit to_p1);
        if (to_p1) begin
            if (m_s1 < 15) m_s1++;
            m_pp1 = 1; m_vx = 2;
            m_st = (m_s1 == 10) ? 3 : 1;
        end else begin
            if (m_s2 < 15) m_s2++;
            m_pp2 = 1; m_vx = -2;
            m_st = (m_s2 == 10) ? 3 : 1;
        end
        m_x = 315; m_y = 235;
    endtask

    task automatic model_step(input bit s, input bit t, input int a, input int b);
        bit rise;
        int nx, ny, pa, pb;
        rise = s && !m_prev;
        m_prev = s;
        m_pp1 = 0; m_pp2 = 0;
        pa = (a > 430) ? 430 : a;
        pb = (b > 430) ? 430 : b;
        if ((m_st == 0 || m_st == 3) && rise) begin
            m_st = 1; m_s1 = 0; m_s2 = 0; m_vx = 2; m_cnt = 0; m_x = 315; m_y = 235;
        end else if (m_st == 1 && t) begin
            m_cnt++;
            if (m_cnt == 60) begin m_st = 2; m_cnt = 0; end
        end else if (m_st == 2 && t) begin
            nx = m_x + m_vx;
            ny = m_y + m_vy;
            if (m_vx < 0 && m_x < 2) model_point(1'b0);
            else if (m_vx > 0 && nx > 630) model_point(1'b1);
            else begin
                if (m_vx < 0 && m_x >= 30 && nx <= 30 && m_y + 10 > pa && m_y < pa + 50) begin
                    m_x = 30; m_vx = 2;
                end else if (m_vx > 0 && m_x <= 610 && nx >= 610 && m_y + 10 > pb && m_y < pb + 50) begin
                    m_x = 610; m_vx = -2;
                end else m_x = nx;
                if (ny < 0) begin m_y = 0; m_vy = 2; end
                else if (ny > 470) begin m_y = 470; m_vy = -2; end
                else m_y = ny;
            end
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint pack(input int st, x, y, a, b, q1, q2);
        return (longint'(st) << 40) | (longint'(x) << 28) | (longint'(y) << 16)
             | (longint'(a) << 8) | (longint'(b) << 4) | (longint'(q1) << 1) | longint'(q2);
    endfunction

    // drive at negedge, let the DUT take the edge, compare at the next negedge
    task automatic step(input bit s, input bit t, input int a, input int b);
        start = s; tick = t; p1_pos = 10'(a); p2_pos = 10'(b);
        @(posedge board_clk);
        model_step(s, t, a, b);
        @(negedge board_clk);
        chk("model", pack(int'(state), int'(ball_x), int'(ball_y), int'(p1_score),
                          int'(p2_score), int'(point_p1), int'(point_p2)),
            pack(m_st, m_x, m_y, m_s1, m_s2, m_pp1, m_pp2));
    endtask

    typedef struct {
        bit s; bit t; int reps; int st; int x; int y;
    } vec_t;
    vec_t tbl[8];

    initial begin
        bit s;
        int a, b, guard;
        tbl[0] = '{0, 0, 2,  0, 315, 235};   // idle after reset
        tbl[1] = '{1, 0, 1,  1, 315, 235};   // start rise -> serve
        tbl[2] = '{1, 1, 59, 1, 315, 235};   // serve ticks 1..59
        tbl[3] = '{0, 1, 1,  2, 315, 235};   // tick 60 -> play
        tbl[4] = '{0, 0, 3,  2, 315, 235};   // no tick, no motion
        tbl[5] = '{0, 1, 1,  2, 317, 237};
        tbl[6] = '{0, 1, 1,  2, 319, 239};
        tbl[7] = '{1, 0, 1,  2, 319, 239};   // start ignored in play

        reset = 1'b1; start = 1'b0; tick = 1'b0; p1_pos = '0; p2_pos = '0;
        repeat (3) @(negedge board_clk);
        model_reset();
        reset = 1'b0;
        chk("reset_state", int'(state), 0);
        chk("reset_score", int'({p1_score, p2_score}), 0);

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                step(tbl[i].s, tbl[i].t, 0, 0);
                chk($sformatf("tbl%0d_state", i), int'(state), tbl[i].st);
                chk($sformatf("tbl%0d_xy", i), int'({ball_x, ball_y}), (tbl[i].x << 10) | tbl[i].y);
            end
        end

        // ball runs right past a paddle parked at the top: x 319 -> 629 then miss
        repeat (155) step(1'b0, 1'b1, 0, 0);
        chk("pre_miss_x", int'(ball_x), 629);
        step(1'b0, 1'b1, 0, 0);
        chk("miss_state", int'(state), 1);
        chk("miss_pulse", int'(point_p1), 1);
        chk("miss_score", int'(p1_score), 1);
        chk("miss_recentre", int'(ball_x), 315);
        step(1'b0, 1'b0, 0, 0);
        chk("pulse_one_cycle", int'(point_p1), 0);

        // randomized play with paddles that sometimes track the ball
        s = 1'b0;
        for (int c = 0; c < 40000 && errors < 8; c++) begin
            if ($urandom_range(0, 199) == 0) s = ~s;
            a = ($urandom_range(0, 9) < 4) ? m_y - int'($urandom_range(0, 45)) : int'($urandom_range(0, 1023));
            b = ($urandom_range(0, 9) < 4) ? m_y - int'($urandom_range(0, 45)) : int'($urandom_range(0, 1023));
            if (a < 0) a = 0;
            if (b < 0) b = 0;
            step(s, $urandom_range(0, 3) != 0, a, b);
        end

        // asynchronous reset in the middle of a rally
        guard = 0;
        while (m_st != 2 && guard < 2000) begin
            s = ~s;
            step(s, 1'b1, 0, 0);
            guard++;
        end
        chk("reach_play", m_st, 2);
        #2 reset = 1'b1;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_score", int'({p1_score, p2_score}), 0);
        chk("async_ball", int'({ball_x, ball_y}), (315 << 10) | 235);
        @(negedge board_clk);
        reset = 1'b0;
        model_reset();
        step(1'b0, 1'b1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
